// File: rtl/sha256_top.sv
// Single-block SHA-256: pads a MSG_SIZE-bit message, runs a fully unrolled
// 64-round compression combinationally, and also registers the digest.
`timescale 1ns/1ps
module sha256_top #(
  parameter int MSG_SIZE    = 96,
  parameter int PADDED_SIZE = 512
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [MSG_SIZE-1:0] message,
  output logic [255:0]        hashed,
  output logic [255:0]        hashed_q
);

  if (PADDED_SIZE != 512) begin : g_bad_padded_size
    $error("sha256_top: PADDED_SIZE must be 512");
  end
  if (MSG_SIZE < 1 || MSG_SIZE > 447) begin : g_bad_msg_size
    $error("sha256_top: MSG_SIZE must be in 1..447");
  end

  localparam logic [255:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  localparam logic [0:63][31:0] K = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [255:0] sha_round(input logic [255:0] s,
                                             input logic [31:0]  k,
                                             input logic [31:0]  w);
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    {a, b, c, d, e, f, g, h} = s;
    t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + k + w;
    t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
    return {t1 + t2, a, b, c, d + t1, e, f, g};
  endfunction

  // First message bit lands in block[511]; length field is always 64-bit big-endian.
  logic [511:0] block;
  always_comb begin
    block                 = '0;
    block[511 -: MSG_SIZE] = message;
    block[511 - MSG_SIZE]  = 1'b1;
    block[63:0]            = 64'(MSG_SIZE);
  end

  for (genvar t = 0; t < 64; t++) begin : g_w
    logic [31:0] w;
    if (t < 16) begin : g_load
      assign w = block[511 - 32*t -: 32];
    end else begin : g_expand
      assign w = ssig1(g_w[t-2].w) + g_w[t-7].w + ssig0(g_w[t-15].w) + g_w[t-16].w;
    end
  end

  for (genvar r = 0; r < 64; r++) begin : g_rnd
    logic [255:0] st_in;
    logic [255:0] st_out;
    if (r == 0) begin : g_first
      assign st_in = IV;
    end else begin : g_chain
      assign st_in = g_rnd[r-1].st_out;
    end
    assign st_out = sha_round(st_in, K[r], g_w[r].w);
  end

  logic [255:0] st_fin;
  assign st_fin = g_rnd[63].st_out;

  always_comb begin
    hashed = '0;
    for (int i = 0; i < 8; i++) begin
      hashed[255 - 32*i -: 32] = IV[255 - 32*i -: 32] + st_fin[255 - 32*i -: 32];
    end
  end

  logic [255:0] dig_d, dig_q;
  assign dig_d    = hashed;
  assign hashed_q = dig_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dig_q <= '0;
    else        dig_q <= dig_d;
  end

endmodule

// File: tb/tb_sha256_top.sv
// Directed checks of sha256_top against published digests and a loop-based
// reference model of SHA-256 for the 96-bit configuration.
`timescale 1ns/1ps
module tb_sha256_top;

  localparam logic [255:0] ABC_DIG   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] HELLO_DIG = 256'h2cf24dba5fb0a30e26e83b2ac5b9e29e1b161e5c1fa7425e73043362938b9824;

  localparam logic [31:0] RIV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  localparam logic [31:0] RK [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  logic         clk = 1'b0;
  logic         rst_n;
  logic [95:0]  msg96;
  logic [23:0]  msg24;
  logic [39:0]  msg40;
  logic [255:0] h96, q96, h24, q24, h40, q40;

  int n_checks = 0;
  int n_fail   = 0;

  logic [255:0] exp_prev;
  logic         have_prev = 1'b0;
  logic [255:0] last_h;
  logic [255:0] h_zero, h_bit0, h_bit95;

  always #5 clk = ~clk;

  sha256_top u_dut (.clk(clk), .rst_n(rst_n), .message(msg96), .hashed(h96), .hashed_q(q96));
  sha256_top #(.MSG_SIZE(24)) u_abc (.clk(clk), .rst_n(rst_n), .message(msg24), .hashed(h24), .hashed_q(q24));
  sha256_top #(.MSG_SIZE(40)) u_hello (.clk(clk), .rst_n(rst_n), .message(msg40), .hashed(h40), .hashed_q(q40));

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x} >> n;
    return d[31:0];
  endfunction

  function automatic logic [511:0] pad96(input logic [95:0] m);
    return {m, 1'b1, 351'b0, 64'd96};
  endfunction

  function automatic logic [255:0] ref_sha(input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] s0, s1, t1, t2;
    logic [255:0] res;
    for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = s1 + w[i-7] + s0 + w[i-16];
    end
    for (int j = 0; j < 8; j++) v[j] = RIV[j];
    for (int i = 0; i < 64; i++) begin
      t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + RK[i] + w[i];
      t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int j = 7; j > 0; j--) v[j] = v[j-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    for (int j = 0; j < 8; j++) res[255 - 32*j -: 32] = RIV[j] + v[j];
    return res;
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_differ(input string tag, input logic [255:0] x, input logic [255:0] y);
    n_checks++;
    assert (x !== y) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected a different digest from %h", tag, x, y);
    end
  endtask

  // Apply a message 1 ns after the rising edge; check hashed_q for the previous one first.
  task automatic drive96(input logic [95:0] m, input string tag);
    @(posedge clk); #1;
    if (have_prev) check({tag, "_qprev"}, q96, exp_prev);
    msg96     = m;
    exp_prev  = ref_sha(pad96(m));
    have_prev = 1'b1;
    @(negedge clk);
    check(tag, h96, exp_prev);
    last_h = h96;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish before 200000 ns");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [95:0] m;
    rst_n = 1'b0;
    msg96 = '0;
    msg24 = 24'h616263;
    msg40 = 40'h68656c6c6f;
    #2;
    check("rst_q96", q96, '0);
    check("rst_q24", q24, '0);
    check("rst_q40", q40, '0);
    check("rst_comb96", h96, ref_sha(pad96(96'h0)));
    #10 rst_n = 1'b1;
    exp_prev  = ref_sha(pad96(96'h0));
    have_prev = 1'b1;

    @(negedge clk);
    check("abc_comb", h24, ABC_DIG);
    check("hello_comb", h40, HELLO_DIG);
    @(posedge clk); #1;
    check("abc_q", q24, ABC_DIG);
    check("hello_q", q40, HELLO_DIG);

    drive96(96'h0, "zero");
    h_zero = last_h;
    drive96(96'h1, "bit0");
    h_bit0 = last_h;
    drive96(96'h800000000000000000000000, "bit95");
    h_bit95 = last_h;
    check_differ("bit0_vs_zero", h_bit0, h_zero);
    check_differ("bit95_vs_zero", h_bit95, h_zero);
    check_differ("bit0_vs_bit95", h_bit0, h_bit95);
    drive96({96{1'b1}}, "ones");
    drive96(96'h68656c6c6f20776f726c6421, "hello_world_bang");

    for (int i = 0; i < 16; i++) begin
      m = {$urandom, $urandom, $urandom};
      drive96(m, "rand");
    end

    // Asynchronous reset between clock edges while the message keeps changing.
    #2 rst_n = 1'b0;
    #1;
    check("midrst_q96", q96, '0);
    check("midrst_q24", q24, '0);
    check("midrst_comb", h96, exp_prev);
    msg96 = 96'h0123456789abcdef01234567;
    exp_prev = ref_sha(pad96(msg96));
    #1;
    check("midrst_track", h96, exp_prev);
    @(posedge clk); #1;
    check("midrst_hold", q96, '0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_q", q96, exp_prev);
    check("post_rst_abc_q", q24, ABC_DIG);

    drive96(96'hfedcba9876543210fedcba98, "tail");
    @(posedge clk); #1;
    check("tail_q", q96, exp_prev);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
